// File: rtl/branch_predictor_if.sv
// Branch-prediction handshake between the fetch/hazard/execute pipeline
// (master) and the dual-issue BTB predictor (slave).
interface branch_predictor_if;
  logic [31:0] pcf;
  logic        pred_taken1f, pred_taken2f;
  logic [31:0] pred_targetf;
  logic        stall1d, stall2d, flush1d, flush2d;
  logic        stall1e, stall2e, flush1e, flush2e;
  logic        prediction1e, prediction2e;
  logic        branch1e, branch2e, taken1e, taken2e;
  logic [31:0] pc1e, pc2e, branch_target1e, branch_target2e;

  modport master (
    output pcf,
    output stall1d, stall2d, flush1d, flush2d,
    output stall1e, stall2e, flush1e, flush2e,
    output branch1e, branch2e, taken1e, taken2e,
    output pc1e, pc2e, branch_target1e, branch_target2e,
    input  pred_taken1f, pred_taken2f, pred_targetf,
    input  prediction1e, prediction2e
  );

  modport slave (
    input  pcf,
    input  stall1d, stall2d, flush1d, flush2d,
    input  stall1e, stall2e, flush1e, flush2e,
    input  branch1e, branch2e, taken1e, taken2e,
    input  pc1e, pc2e, branch_target1e, branch_target2e,
    output pred_taken1f, pred_taken2f, pred_targetf,
    output prediction1e, prediction2e
  );
endinterface

// File: rtl/branch_predictor.sv
// Dual-issue direct-mapped BTB with 2-bit counters: Fetch lookup for PCF and
// PCF+4, per-slot prediction pipeline to Execute, training from Execute.
module branch_predictor #(
  parameter int IDX_BITS = 6
) (
  input  logic             clk,
  input  logic             reset,
  branch_predictor_if.slave bp
);
  localparam int ENTRIES  = 1 << IDX_BITS;
  localparam int TAG_BITS = 30 - IDX_BITS;

  typedef logic [IDX_BITS-1:0] idx_t;
  typedef logic [TAG_BITS-1:0] tag_t;

  typedef struct packed {
    logic        valid;
    tag_t        tag;
    logic [31:0] target;
    logic [1:0]  ctr;
  } entry_t;

  localparam entry_t RESET_ENTRY = '{valid: 1'b0, tag: '0, target: '0, ctr: 2'b01};

  entry_t btb [ENTRIES];

  function automatic idx_t pc_idx(input logic [31:0] pc);
    return pc[IDX_BITS+1:2];
  endfunction

  function automatic tag_t pc_tag(input logic [31:0] pc);
    return pc[31:IDX_BITS+2];
  endfunction

  function automatic logic entry_hit(input entry_t e, input logic [31:0] pc);
    return e.valid && (e.tag == pc_tag(pc));
  endfunction

  // Next value of an entry after one resolved branch; a miss that was not
  // taken leaves the entry untouched (the caller also suppresses the write).
  function automatic entry_t train(input entry_t e, input logic hit,
                                   input logic taken, input logic [31:0] pc,
                                   input logic [31:0] tgt);
    entry_t n;
    n = e;
    if (hit) begin
      if (taken && e.ctr != 2'b11)       n.ctr = e.ctr + 2'd1;
      else if (!taken && e.ctr != 2'b00) n.ctr = e.ctr - 2'd1;
      if (taken) n.target = tgt;
    end else if (taken) begin
      n = '{valid: 1'b1, tag: pc_tag(pc), target: tgt, ctr: 2'b10};
    end
    return n;
  endfunction

  // Fetch lookup
  logic [31:0] pc2f;
  entry_t      e1f, e2f;
  logic        taken1_raw, taken2_raw;
  logic        pred1f, pred2f;

  // NOTE: every always_comb output is assigned on every path, so no latch is inferred.
  always_comb begin
    pc2f       = bp.pcf + 32'd4;
    e1f        = btb[pc_idx(bp.pcf)];
    e2f        = btb[pc_idx(pc2f)];
    taken1_raw = entry_hit(e1f, bp.pcf) && e1f.ctr[1];
    taken2_raw = entry_hit(e2f, pc2f) && e2f.ctr[1];
    pred1f     = taken1_raw;
    pred2f     = taken2_raw && !taken1_raw;
  end

  assign bp.pred_taken1f = pred1f;
  assign bp.pred_taken2f = pred2f;
  assign bp.pred_targetf = pred1f ? e1f.target : (pred2f ? e2f.target : 32'd0);

  // Prediction pipeline F->D->E
  logic pred1_d, pred2_d, pred1_e, pred2_e;

  // NOTE: state registers use non-blocking assignments so all flops sample
  // the pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (reset) begin
      pred1_d <= 1'b0;
      pred2_d <= 1'b0;
      pred1_e <= 1'b0;
      pred2_e <= 1'b0;
    end else begin
      if (bp.flush1d)      pred1_d <= 1'b0;
      else if (!bp.stall1d) pred1_d <= pred1f;
      if (bp.flush2d)      pred2_d <= 1'b0;
      else if (!bp.stall2d) pred2_d <= pred2f;
      if (bp.flush1e)      pred1_e <= 1'b0;
      else if (!bp.stall1e) pred1_e <= pred1_d;
      if (bp.flush2e)      pred2_e <= 1'b0;
      else if (!bp.stall2e) pred2_e <= pred2_d;
    end
  end

  assign bp.prediction1e = pred1_e;
  assign bp.prediction2e = pred2_e;

  // Training from Execute
  idx_t   idx1e, idx2e;
  entry_t e1e, e2e, new1e, new2e;
  logic   hit1e, hit2e, we1, we2, wrong_path;

  always_comb begin
    idx1e      = pc_idx(bp.pc1e);
    idx2e      = pc_idx(bp.pc2e);
    e1e        = btb[idx1e];
    e2e        = btb[idx2e];
    hit1e      = entry_hit(e1e, bp.pc1e);
    hit2e      = entry_hit(e2e, bp.pc2e);
    new1e      = train(e1e, hit1e, bp.taken1e, bp.pc1e, bp.branch_target1e);
    new2e      = train(e2e, hit2e, bp.taken2e, bp.pc2e, bp.branch_target2e);
    we1        = bp.branch1e && (hit1e || bp.taken1e);
    // Slot 2 is younger: a slot-1 mispredict puts it on the wrong path.
    wrong_path = bp.branch1e && (bp.taken1e != pred1_e);
    we2        = bp.branch2e && (hit2e || bp.taken2e) && !wrong_path &&
                 !(we1 && (idx1e == idx2e));
  end

  // NOTE: the table is reset entry by entry because valid bits and counters
  // must start from known values; this keeps it in flops rather than RAM.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < ENTRIES; i++) btb[i] <= RESET_ENTRY;
    end else begin
      if (we1) btb[idx1e] <= new1e;
      if (we2) btb[idx2e] <= new2e;
    end
  end
endmodule

// File: tb/tb_branch_predictor.sv
// Directed self-checking bench for branch_predictor: reset, allocation,
// counter saturation, pipeline stall/flush, wrong-path, collision, wrap.
module tb_branch_predictor;
  logic clk = 1'b0;
  logic reset;
  int   vectors = 0;
  int   miscompares = 0;

  always #5 clk = ~clk;

  branch_predictor_if bp ();

  branch_predictor #(.IDX_BITS(6)) dut (
    .clk   (clk),
    .reset (reset),
    .bp    (bp)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp)
    else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Inputs change 1 time unit after the rising edge; outputs are sampled 1 unit later.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic look(input logic [31:0] pc);
    bp.pcf = pc;
    #1;
  endtask

  task automatic idle();
    bp.branch1e = 1'b0; bp.taken1e = 1'b0; bp.pc1e = '0; bp.branch_target1e = '0;
    bp.branch2e = 1'b0; bp.taken2e = 1'b0; bp.pc2e = '0; bp.branch_target2e = '0;
  endtask

  task automatic train1(input logic [31:0] pc, input logic tk, input logic [31:0] tgt);
    bp.pcf = '0;
    bp.branch1e = 1'b1; bp.pc1e = pc; bp.taken1e = tk; bp.branch_target1e = tgt;
    tick();
    idle();
  endtask

  initial begin
    reset = 1'b1;
    bp.pcf = 32'h40;
    bp.stall1d = 0; bp.stall2d = 0; bp.flush1d = 0; bp.flush2d = 0;
    bp.stall1e = 0; bp.stall2e = 0; bp.flush1e = 0; bp.flush2e = 0;
    idle();
    tick();
    tick();
    look(32'h40);
    check("rst_taken1f", bp.pred_taken1f, 0);
    check("rst_taken2f", bp.pred_taken2f, 0);
    check("rst_target", bp.pred_targetf, 0);
    check("rst_pred1e", bp.prediction1e, 0);
    check("rst_pred2e", bp.prediction2e, 0);
    reset = 1'b0;

    // Allocate 0x40 -> 0x100 (counter 10)
    train1(32'h40, 1, 32'h100);
    look(32'h40);
    check("alloc_taken1f", bp.pred_taken1f, 1);
    check("alloc_target1", bp.pred_targetf, 32'h100);
    check("alloc_taken2f_miss", bp.pred_taken2f, 0);
    look(32'h3C);
    check("alloc_slot2_taken1f", bp.pred_taken1f, 0);
    check("alloc_slot2_taken2f", bp.pred_taken2f, 1);
    check("alloc_slot2_target", bp.pred_targetf, 32'h100);

    // Saturation: 10 -> 11 -> 11 -> 11, then down to 10, 01
    for (int i = 0; i < 3; i++) train1(32'h40, 1, 32'h100);
    train1(32'h40, 0, 32'h0);
    look(32'h40);
    check("sat_one_nt", bp.pred_taken1f, 1);
    train1(32'h40, 0, 32'h0);
    look(32'h40);
    check("sat_two_nt", bp.pred_taken1f, 0);
    for (int i = 0; i < 4; i++) train1(32'h40, 0, 32'h0);
    look(32'h40);
    check("sat_floor_nt", bp.pred_taken1f, 0);
    train1(32'h40, 1, 32'h100);   // 00 -> 01 (would be 10 if it had wrapped)
    look(32'h40);
    check("sat_floor_held", bp.pred_taken1f, 0);
    train1(32'h40, 1, 32'h100);   // 01 -> 10
    look(32'h40);
    check("sat_back_taken", bp.pred_taken1f, 1);

    // Pipeline: nominal latency t+2
    look(32'h0); tick(); tick();
    look(32'h40); tick();
    look(32'h0);  tick();
    check("pipe_t2", bp.prediction1e, 1);
    tick();
    check("pipe_t3_drained", bp.prediction1e, 0);

    // Stall1D in t+1 extends the prediction to t+3
    look(32'h40); tick();
    look(32'h0); bp.stall1d = 1; tick();
    bp.stall1d = 0; tick();
    check("stall_d_t3", bp.prediction1e, 1);
    tick();
    check("stall_d_t4", bp.prediction1e, 0);

    // Stall1E holds, flush1E beats stall1E
    look(32'h40); tick();
    look(32'h0);  tick();
    check("stall_e_t2", bp.prediction1e, 1);
    bp.stall1e = 1; tick();
    check("stall_e_hold", bp.prediction1e, 1);
    bp.flush1e = 1; tick();
    check("flush_over_stall", bp.prediction1e, 0);
    bp.flush1e = 0; bp.stall1e = 0;

    // Slot-2 pipeline
    look(32'h3C); tick();
    look(32'h0);  tick();
    check("pipe2_t2", bp.prediction2e, 1);
    check("pipe2_slot1_quiet", bp.prediction1e, 0);

    // Wrong-path: slot-1 mispredict (pred 0, taken 1) drops slot-2 training
    tick();
    check("wp_pred1e_zero", bp.prediction1e, 0);
    bp.branch1e = 1; bp.pc1e = 32'h200; bp.taken1e = 1; bp.branch_target1e = 32'h500;
    bp.branch2e = 1; bp.pc2e = 32'h80;  bp.taken2e = 1; bp.branch_target2e = 32'h300;
    tick();
    idle();
    look(32'h80);
    check("wp_slot2_dropped", bp.pred_taken1f, 0);
    look(32'h200);
    check("wp_slot1_alloc", bp.pred_taken1f, 1);
    check("wp_slot1_target", bp.pred_targetf, 32'h500);

    // Slot-2 trains when slot 1 is idle
    look(32'h0);
    bp.branch2e = 1; bp.pc2e = 32'h80; bp.taken2e = 1; bp.branch_target2e = 32'h300;
    tick();
    idle();
    look(32'h80);
    check("slot2_alloc", bp.pred_taken1f, 1);
    check("slot2_target", bp.pred_targetf, 32'h300);

    // Collision: 0x40 and 0x140 share index 0x10; slot 1 correctly predicted
    look(32'h40); tick();
    look(32'h0);  tick();
    check("coll_pred1e", bp.prediction1e, 1);
    bp.branch1e = 1; bp.pc1e = 32'h40;  bp.taken1e = 1; bp.branch_target1e = 32'h100;
    bp.branch2e = 1; bp.pc2e = 32'h140; bp.taken2e = 1; bp.branch_target2e = 32'h700;
    tick();
    idle();
    look(32'h140);
    check("coll_slot2_dropped", bp.pred_taken1f, 0);
    look(32'h40);
    check("coll_slot1_kept", bp.pred_taken1f, 1);
    check("coll_slot1_target", bp.pred_targetf, 32'h100);

    // Slot priority: 0x3C and 0x40 both predicted taken
    train1(32'h3C, 1, 32'h900);
    look(32'h3C);
    check("prio_taken1f", bp.pred_taken1f, 1);
    check("prio_taken2f_forced", bp.pred_taken2f, 0);
    check("prio_target", bp.pred_targetf, 32'h900);

    // Wrap-around: slot 2 of 0xFFFFFFFC is 0x0
    train1(32'h0, 1, 32'hABC);
    look(32'hFFFF_FFFC);
    check("wrap_taken1f", bp.pred_taken1f, 0);
    check("wrap_taken2f", bp.pred_taken2f, 1);
    check("wrap_target", bp.pred_targetf, 32'hABC);

    // Mid-stream reset overrides training and clears in-flight predictions
    look(32'h40); tick();
    look(32'h0);
    reset = 1'b1;
    bp.branch1e = 1; bp.pc1e = 32'hC0; bp.taken1e = 1; bp.branch_target1e = 32'h123;
    tick();
    reset = 1'b0;
    idle();
    check("mrst_pred1e", bp.prediction1e, 0);
    look(32'h40);
    check("mrst_table_clear", bp.pred_taken1f, 0);
    check("mrst_target", bp.pred_targetf, 0);
    look(32'hC0);
    check("mrst_no_train", bp.pred_taken1f, 0);
    look(32'h0);
    tick();
    check("mrst_pred1e_next", bp.prediction1e, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
